key_switch_io: RTL
==================

// Module: key_switch_io
// PURPOSE
//  Memory-mapped input device on the CPU data bus, beside the timer and data memory.
//  Debounces the raw KEY and SW inputs and exposes them as data/control registers.
//  Each input has a Ready bit (new value), an Overrun bit (value missed) and an
//  interrupt enable. The CPU's memory stage reads and writes these registers over
//  abus/dbus. The two interrupt outputs go to the interrupt logic.
// PARAMETERS
//  DEBOUNCE_CYCLES  10000         stable clocks required before a new input value is accepted (>=2)
//  ADDR_KDATA       32'hF0000010  key data register (read-only)
//  ADDR_SDATA       32'hF0000014  switch data register (read-only)
//  ADDR_KCTRL       32'hF0000110  key control/status register
//  ADDR_SCTRL       32'hF0000114  switch control/status register
// PORTS
//  clk       in   1   system clock
//  reset     in   1   asynchronous reset, active-low
//  abus      in   32  byte address from the memory stage
//  dbus_in   in   32  write data
//  wren      in   1   write strobe, sampled on the rising edge of clk
//  rden      in   1   read strobe; read side effects apply only when rden=1
//  KEY       in   4   raw push buttons, active-low (pressed=0)
//  SW        in   10  raw slide switches
//  dbus_out  out  32  read data; 32'hz when abus matches none of the four addresses
//  intr_key  out  1   KCTRL.Ready & KCTRL.IE
//  intr_sw   out  1   SCTRL.Ready & SCTRL.IE
// BEHAVIOUR
//  Register views
//  - KDATA = {28'b0, ~key_db}: a pressed key reads as 1. SDATA = {22'b0, sw_db}.
//  - CTRL layout: bit0 Ready (RO), bit2 Overrun (write-0-to-clear; writing 1 has no effect),
//    bit8 IE (RW). All other bits read 0.
//  Reads
//  - dbus_out is combinational from abus; there are no read wait states.
//  - A read of xDATA with rden=1 clears that device's Ready bit at the next edge.
//  Debounce
//  - 2-flop synchroniser per input vector.
//  - The counter resets whenever the synchronised value equals the debounced value, or when
//    the synchronised value changes.
//  - Once the counter reaches DEBOUNCE_CYCLES-1, the debounced value takes the synchronised
//    value on that edge, and Ready is set on the same edge.
//  - Latency from a stable raw change is 2+DEBOUNCE_CYCLES clocks.
//  - Any bounce shorter than DEBOUNCE_CYCLES produces no update.
//  Status events
//  - Accepted change while Ready=1: Overrun is set to 1 and Ready stays 1.
//  - Accepted change on the same edge as an xDATA read: Ready stays 1 and Overrun is
//    unchanged (the new event wins).
//  - CTRL write of Overrun=0 on the same edge as a new overrun: Overrun stays 1 (set wins).
//  - A CTRL write updates IE and may clear Overrun; it never changes Ready.
//  - Writes to xDATA addresses are ignored.
//  Reset (asynchronous, any time, including mid-debounce)
//  - Synchroniser and debounced values go to the released state: KEY=4'hF, SW=0.
//  - Counters=0. Ready, Overrun and IE=0.
//  - intr_key and intr_sw go to 0 immediately. dbus_out follows abus combinationally.
//  - A change that was in progress is lost. It is re-detected if the input is still
//    different after reset.
//  Interrupts
//  - Interrupts are level outputs and are registered-derived (no combinational path
//    from KEY/SW).
// STRUCTURE
//  - Shared package io_pkg: the four address constants, CTRL bit indices
//    (CTRL_READY=0, CTRL_OVR=2, CTRL_IE=8), and the timer addresses for decode consistency.
//  - Sub-module io_debounce #(WIDTH, CYCLES, RESET_VAL): synchroniser, stability counter,
//    debounced register and one-cycle 'changed' pulse.
//  - io_debounce is instantiated twice: WIDTH=4 with RESET_VAL=4'hF, and WIDTH=10 with
//    RESET_VAL=0.
//  - The top level holds the status flags, the address decode and the tri-state read mux.
// TESTING (DEBOUNCE_CYCLES=4)
//  1. Reset with KEY=4'hF and SW=0.
//     -> KDATA=0, KCTRL=0, SDATA=0, intr_key=0, intr_sw=0.
//  2. SW=10'h2A5 held.
//     -> SDATA=10'h2A5 and SCTRL=1, both exactly 6 clocks after the change.
//     A read of SDATA with rden=1 -> SCTRL=0.
//  3. KEY[0] toggling every 2 clocks for 20 clocks, then held low.
//     -> no update during the toggling.
//     -> KDATA=1 and Ready=1 after the input has been stable for 6 clocks.
//  4. Two accepted SW changes with no read in between.
//     -> SCTRL=32'h5.
//     Write SCTRL=32'h100 -> SCTRL=32'h101 and intr_sw=1.
//     Read SDATA -> SCTRL=32'h100 and intr_sw=0.
//  5. Accepted key change on the same edge as a KDATA read -> KCTRL.Ready=1 and Overrun=0.
//     Overrun set on the same edge as a write of 0 to KCTRL -> Overrun=1.
//  6. Assert reset mid-debounce (counter=2) and with IE=1 and Ready=1.
//     -> intr_key=0 immediately and all registers return to their reset values.
//     Release reset with SW held -> SDATA updates 6 clocks after release.

Source files
------------

// File: rtl/io_pkg.sv
// Shared constants for the memory-mapped I/O devices on the CPU data bus:
// register addresses, control/status bit positions and a CTRL word builder.
package io_pkg;

  // Key and switch device registers
  localparam logic [31:0] ADDR_KDATA = 32'hF000_0010;
  localparam logic [31:0] ADDR_SDATA = 32'hF000_0014;
  localparam logic [31:0] ADDR_KCTRL = 32'hF000_0110;
  localparam logic [31:0] ADDR_SCTRL = 32'hF000_0114;

  // Timer registers, kept here so every device decodes against one address map
  localparam logic [31:0] ADDR_TCNT  = 32'hF000_0020;
  localparam logic [31:0] ADDR_TLIM  = 32'hF000_0024;
  localparam logic [31:0] ADDR_TCTL  = 32'hF000_0120;

  // CTRL register bit positions
  localparam int CTRL_READY = 0;
  localparam int CTRL_OVR   = 2;
  localparam int CTRL_IE    = 8;

  // Assemble a CTRL read value; bits outside the three flags read 0
  function automatic logic [31:0] ctrl_word(input logic ready, input logic ovr,
                                            input logic ie);
    logic [31:0] w;
    w             = '0;
    w[CTRL_READY] = ready;
    w[CTRL_OVR]   = ovr;
    w[CTRL_IE]    = ie;
    return w;
  endfunction

endpackage

// File: rtl/io_debounce.sv
// Debouncer for a vector of raw asynchronous inputs: 2-flop synchroniser,
// stability counter and debounced register. 'changed' is high during the
// cycle whose closing clock edge loads a new debounced value, so a consumer
// can update its own state on exactly that edge.
module io_debounce #(
  parameter int               WIDTH     = 4,
  parameter int               CYCLES    = 10000,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] db,
  output logic             changed
);

  localparam int              CNT_W    = $clog2(CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [CNT_W-1:0] cnt;
  logic             differs;
  logic             moving;

  // differs: synchronised value is not the accepted one.
  // moving:  synchronised value changes on the next edge, so stability restarts.
  assign differs = (sync2 != db);
  assign moving  = (sync1 != sync2);
  assign changed = differs && !moving && (cnt == CNT_LAST);

  // Two-stage synchroniser for the raw inputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= RESET_VAL;
      sync2 <= RESET_VAL;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Count stable cycles of a differing value; accept it when the count completes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
      db  <= RESET_VAL;
    end else if (!differs || moving) begin
      cnt <= '0;
    end else if (changed) begin
      cnt <= '0;
      db  <= sync2;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/key_switch_io.sv
// Memory-mapped key/switch input device. Debounces KEY and SW, and exposes
// each as a read-only data register plus a control/status register holding
// Ready, Overrun and interrupt enable.
// Bus semantics: wren and rden are single-cycle strobes qualified by abus and
// sampled on the rising clock edge; there is no handshake or wait state. Read
// data on dbus_out is combinational from abus and floats when abus decodes to
// none of this device's registers.
module key_switch_io
  import io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 10000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] abus,
  input  logic [31:0] dbus_in,
  input  logic        wren,
  input  logic        rden,
  input  logic [3:0]  KEY,
  input  logic [9:0]  SW,
  output logic [31:0] dbus_out,
  output logic        intr_key,
  output logic        intr_sw
);

  logic [3:0]  key_db;
  logic        key_chg;
  logic [9:0]  sw_db;
  logic        sw_chg;

  logic        k_ready, k_ovr, k_ie;
  logic        s_ready, s_ovr, s_ie;

  logic        k_rd, k_wr, s_rd, s_wr;
  logic [31:0] rdata;
  logic        hit;
  logic        unused_dbus;

  // Keys are active-low, so the released state is all ones
  io_debounce #(
    .WIDTH    (4),
    .CYCLES   (DEBOUNCE_CYCLES),
    .RESET_VAL(4'hF)
  ) u_key_db (
    .clk    (clk),
    .reset  (reset),
    .raw    (KEY),
    .db     (key_db),
    .changed(key_chg)
  );

  io_debounce #(
    .WIDTH    (10),
    .CYCLES   (DEBOUNCE_CYCLES),
    .RESET_VAL(10'h000)
  ) u_sw_db (
    .clk    (clk),
    .reset  (reset),
    .raw    (SW),
    .db     (sw_db),
    .changed(sw_chg)
  );

  assign k_rd = rden && (abus == ADDR_KDATA);
  assign s_rd = rden && (abus == ADDR_SDATA);
  assign k_wr = wren && (abus == ADDR_KCTRL);
  assign s_wr = wren && (abus == ADDR_SCTRL);

  // Only the Overrun and IE bits of a CTRL write carry meaning
  assign unused_dbus = ^{dbus_in[31:9], dbus_in[7:3], dbus_in[1:0]};

  // Key status: a new value beats a concurrent read, a new overrun beats a clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      k_ready <= 1'b0;
      k_ovr   <= 1'b0;
      k_ie    <= 1'b0;
    end else begin
      if (key_chg)   k_ready <= 1'b1;
      else if (k_rd) k_ready <= 1'b0;

      if (key_chg && k_ready && !k_rd)     k_ovr <= 1'b1;
      else if (k_wr && !dbus_in[CTRL_OVR]) k_ovr <= 1'b0;

      if (k_wr) k_ie <= dbus_in[CTRL_IE];
    end
  end

  // Switch status: same rules as the key status
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_ready <= 1'b0;
      s_ovr   <= 1'b0;
      s_ie    <= 1'b0;
    end else begin
      if (sw_chg)    s_ready <= 1'b1;
      else if (s_rd) s_ready <= 1'b0;

      if (sw_chg && s_ready && !s_rd)      s_ovr <= 1'b1;
      else if (s_wr && !dbus_in[CTRL_OVR]) s_ovr <= 1'b0;

      if (s_wr) s_ie <= dbus_in[CTRL_IE];
    end
  end

  // Interrupts come only from flops, never straight from KEY/SW
  assign intr_key = k_ready && k_ie;
  assign intr_sw  = s_ready && s_ie;

  // Read mux: decode abus to one of the four registers
  always_comb begin
    rdata = '0;
    hit   = 1'b1;
    case (abus)
      ADDR_KDATA: rdata = {28'b0, ~key_db};
      ADDR_SDATA: rdata = {22'b0, sw_db};
      ADDR_KCTRL: rdata = ctrl_word(k_ready, k_ovr, k_ie);
      ADDR_SCTRL: rdata = ctrl_word(s_ready, s_ovr, s_ie);
      default:    hit   = 1'b0;
    endcase
  end

  assign dbus_out = hit ? rdata : 32'hz;

endmodule
